// File: rtl/zoom_hdmi_pkg.sv
// Shared definitions for the zoom-to-HDMI output path: FSM encoding,
// default 720p timing and RGB field layout.
package zoom_hdmi_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int CNT_W = 12;
  localparam int PIX_W = 24;
  localparam int CH_W  = 8;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  function automatic logic in_win(input logic [CNT_W-1:0] c,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/zoom_hdmi_delay_line.sv
// Fixed-depth register shift line; aligns timing flags with FIFO read latency.
module zoom_hdmi_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/zoom_hdmi_timing_gen.sv
// HDMI timing generator reading pixels from the zoom FIFO; realigns FIFO
// data with delayed sync/DE and flags pixels lost to FIFO underflow.
module zoom_hdmi_timing_gen
  import zoom_hdmi_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] fifo_rd_data,
  input  logic        fifo_rd_empty,
  input  logic        fifo_almost_full,
  output logic        fifo_rd_en,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic        vid_de,
  output logic [23:0] vid_data,
  output logic        frame_start,
  output logic        underflow,
  output logic        underflow_sticky
);

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_HS_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_TOT_M1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_VS_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_TOT_M1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  state_t           state_p0;
  logic [CNT_W-1:0] h_cnt_p0;
  logic [CNT_W-1:0] v_cnt_p0;

  logic h_last, v_last, run, de_i, hs_i, vs_i, to_idle;
  logic de_dly, hs_dly, vs_dly, vld_dly;

  assign run         = (state_p0 == RUN);
  assign h_last      = (h_cnt_p0 == H_TOT_M1);
  assign v_last      = (v_cnt_p0 == V_TOT_M1);
  assign de_i        = run && (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
  assign hs_i        = run && in_win(h_cnt_p0, H_HS_LO, H_HS_HI);
  assign vs_i        = run && in_win(v_cnt_p0, V_VS_LO, V_VS_HI);
  assign fifo_rd_en  = de_i && !fifo_rd_empty;
  assign frame_start = run && (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
  assign to_idle     = ((state_p0 == WAIT_FILL) && !enable) ||
                       (run && h_last && v_last && !enable);

  // Stage 0: run control and raster counters; stopping only at the last
  // cycle of a frame keeps counters at (0,0) whenever RUN is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          h_cnt_p0 <= '0;
          v_cnt_p0 <= '0;
          if (enable) state_p0 <= WAIT_FILL;
        end
        WAIT_FILL: begin
          if (!enable)               state_p0 <= IDLE;
          else if (fifo_almost_full) state_p0 <= RUN;
        end
        RUN: begin
          if (h_last) begin
            h_cnt_p0 <= '0;
            if (v_last) begin
              v_cnt_p0 <= '0;
              if (!enable) state_p0 <= IDLE;
            end else begin
              v_cnt_p0 <= v_cnt_p0 + 1'b1;
            end
          end else begin
            h_cnt_p0 <= h_cnt_p0 + 1'b1;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // Stages 1..RD_LAT: timing flags wait for the FIFO read data
  zoom_hdmi_delay_line #(
    .WIDTH (4),
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({de_i, hs_i, vs_i, fifo_rd_en}),
    .dout  ({de_dly, hs_dly, vs_dly, vld_dly})
  );

  // Output stage: skipped reads show as black pixels with an underflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_de           <= 1'b0;
      vid_hs           <= ~HS_POL;
      vid_vs           <= ~VS_POL;
      vid_data         <= '0;
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      vid_de    <= de_dly;
      vid_hs    <= hs_dly ? HS_POL : ~HS_POL;
      vid_vs    <= vs_dly ? VS_POL : ~VS_POL;
      vid_data  <= vld_dly ? {fifo_rd_data[R_LSB +: CH_W],
                              fifo_rd_data[G_LSB +: CH_W],
                              fifo_rd_data[B_LSB +: CH_W]} : '0;
      underflow <= de_dly && !vld_dly;
      if (to_idle)                  underflow_sticky <= 1'b0;
      else if (de_dly && !vld_dly)  underflow_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zoom_hdmi_timing_gen.sv
// Scoreboard bench: small raster (14x7), latency-2 FIFO model, two DUTs
// differing only in sync polarity.
module tb_zoom_hdmi_timing_gen;

  typedef struct {
    logic [23:0] data;
    logic        uf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_rd_empty = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic [23:0] fifo_rd_data = '0;
  logic [23:0] fifo_s1 = '0;
  int          rd_ptr = 0;

  logic        rd_en, hs, vs, de, fs, uf, ufs;
  logic [23:0] data;
  logic        rd_en2, hs2, vs2, de2, fs2, uf2, ufs2;
  logic [23:0] data2;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  int de_cnt = 0, de2_cnt = 0, fs_cnt = 0;
  int hs_n1 = 0, hs_n2 = 0, vs_n1 = 0, vs_n2 = 0;
  int hs_w1 = 0, hs_w2 = 0, vs_w1 = 0, vs_w2 = 0;
  int s_de, s_de2, s_fs, s_hs1, s_hs2, s_vs1, s_vs2;

  always #5 clk = ~clk;

  zoom_hdmi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_rd_en(rd_en),
    .vid_hs(hs), .vid_vs(vs), .vid_de(de), .vid_data(data),
    .frame_start(fs), .underflow(uf), .underflow_sticky(ufs)
  );

  zoom_hdmi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2)
  ) dut_neg (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_rd_en(rd_en2),
    .vid_hs(hs2), .vid_vs(vs2), .vid_de(de2), .vid_data(data2),
    .frame_start(fs2), .underflow(uf2), .underflow_sticky(ufs2)
  );

  // FIFO model: word i is 0xFFFFFF - i, two-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      fifo_s1 <= 24'hFFFFFF - 24'(rd_ptr);
      rd_ptr  <= rd_ptr + 1;
    end
    fifo_rd_data <= fifo_s1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every displayed pixel, measures sync pulses
  always @(negedge clk) begin
    exp_t e;
    if (fs) fs_cnt++;
    if (de2) de2_cnt++;
    if (de) begin
      de_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_de: got data %0h expected no pixel at %0t", data, $time);
      end else begin
        e = q.pop_front();
        chk("pix_data", 32'(data), 32'(e.data));
        chk("pix_underflow", 32'(uf), 32'(e.uf));
        chk("pix_data_neg", 32'(data2), 32'(e.data));
        chk("pix_underflow_neg", 32'(uf2), 32'(e.uf));
      end
    end
    if (hs == 1'b1) hs_w1++;
    else if (hs_w1 != 0) begin chk("hs_width", hs_w1, 2); hs_n1++; hs_w1 = 0; end
    if (hs2 == 1'b0) hs_w2++;
    else if (hs_w2 != 0) begin chk("hs_width_neg", hs_w2, 2); hs_n2++; hs_w2 = 0; end
    if (vs == 1'b1) vs_w1++;
    else if (vs_w1 != 0) begin chk("vs_width", vs_w1, 14); vs_n1++; vs_w1 = 0; end
    if (vs2 == 1'b0) vs_w2++;
    else if (vs_w2 != 0) begin chk("vs_width_neg", vs_w2, 14); vs_n2++; vs_w2 = 0; end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic snap();
    s_de = de_cnt; s_de2 = de2_cnt; s_fs = fs_cnt;
    s_hs1 = hs_n1; s_hs2 = hs_n2; s_vs1 = vs_n1; s_vs2 = vs_n2;
  endtask

  task automatic chk_counts(input int ede, input int ehs, input int evs, input int efs);
    chk("de_count", de_cnt - s_de, ede);
    chk("de_count_neg", de2_cnt - s_de2, ede);
    chk("hs_pulses", hs_n1 - s_hs1, ehs);
    chk("hs_pulses_neg", hs_n2 - s_hs2, ehs);
    chk("vs_pulses", vs_n1 - s_vs1, evs);
    chk("vs_pulses_neg", vs_n2 - s_vs2, evs);
    chk("frame_starts", fs_cnt - s_fs, efs);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_en"}, 32'({rd_en, rd_en2}), 0);
    chk({tag, "_fs"}, 32'({fs, fs2}), 0);
    chk({tag, "_de"}, 32'({de, de2}), 0);
    chk({tag, "_sync"}, 32'({hs, vs, hs2, vs2}), 32'h3);
    chk({tag, "_data"}, 32'(data | data2), 0);
    chk({tag, "_underflow"}, 32'({uf, uf2}), 0);
    chk({tag, "_queue_left"}, q.size(), 0);
  endtask

  task automatic push_frame(input int base);
    for (int i = 0; i < 32; i++) q.push_back('{24'hFFFFFF - 24'(base + i), 1'b0});
  endtask

  initial begin
    // reset state
    tick(2);
    chk_quiet("reset");
    chk("reset_sticky", 32'({ufs, ufs2}), 0);
    rst_n = 1'b1;

    // start-up gated on prefill, then one stopped frame (words 0..31)
    snap();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i == 19) chk("prefill_wait", 32'({rd_en, rd_en2, de, de2}), 0);
    end
    push_frame(0);
    fifo_almost_full = 1'b1;
    tick(1);
    chk("start_fs", 32'({fs, fs2}), 32'h3);
    chk("start_rd_en", 32'({rd_en, rd_en2}), 32'h3);
    fifo_almost_full = 1'b0;
    tick(2);
    chk("first_de_early", 32'(de), 0);
    tick(1);
    chk("first_de", 32'(de), 1);
    chk("first_data", 32'(data), 32'hFFFFFF);
    tick(46);
    enable = 1'b0;
    tick(60);
    chk_counts(32, 7, 1, 1);
    chk_quiet("stop");

    // underflow on pixels 3-4 of line 0 (words 32..61, two pixels lost)
    snap();
    for (int i = 0; i < 32; i++) begin
      if (i == 3 || i == 4) q.push_back('{24'h000000, 1'b1});
      else q.push_back('{24'hFFFFFF - 24'(32 + i - (i > 4 ? 2 : 0)), 1'b0});
    end
    enable = 1'b1;
    tick(2);
    fifo_almost_full = 1'b1;
    tick(1);
    fifo_almost_full = 1'b0;
    chk("uf_run_fs", 32'(fs), 1);
    tick(3);
    fifo_rd_empty = 1'b1;
    tick(2);
    fifo_rd_empty = 1'b0;
    tick(3);
    chk("sticky_set", 32'({ufs, ufs2}), 32'h3);
    tick(41);
    enable = 1'b0;
    tick(60);
    chk_counts(32, 7, 1, 1);
    chk("sticky_cleared", 32'({ufs, ufs2}), 0);
    chk_quiet("uf_stop");

    // async reset in line 2 (words 62..77 shown, 78..79 read then lost)
    snap();
    for (int i = 0; i < 16; i++) q.push_back('{24'hFFFFFF - 24'(62 + i), 1'b0});
    enable = 1'b1;
    tick(2);
    fifo_almost_full = 1'b1;
    tick(1);
    fifo_almost_full = 1'b0;
    tick(30);
    rst_n = 1'b0;
    #1;
    chk_quiet("midreset");
    chk("midreset_sticky", 32'({ufs, ufs2}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("refill_wait", 32'({rd_en, rd_en2, de, de2, fs}), 0);
    push_frame(80);
    fifo_almost_full = 1'b1;
    tick(1);
    fifo_almost_full = 1'b0;
    chk("restart_fs", 32'(fs), 1);
    tick(46);
    enable = 1'b0;
    tick(60);
    chk_counts(48, 9, 1, 2);
    chk_quiet("restart_stop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zoom_hdmi_timing_gen.md
# zoom_hdmi_timing_gen

Downstream consumer of the 24-bit zoom→HDMI asynchronous FIFO, in the pixel-clock domain. It generates HDMI video timing (hsync, vsync, data-enable) and issues FIFO reads for every active pixel. It re-aligns FIFO read data with the delayed timing signals and drives the registered RGB/sync bus into the HDMI encoder. It also gates start-up on FIFO prefill, stops only on frame boundaries, and flags FIFO underflow.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (cycles)
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- HS_POL, 1, active level of vid_hs
- VS_POL, 1, active level of vid_vs
- RD_LAT, 2, FIFO read latency (rd_en to valid rd_data; output register enabled)

Ports:
- clk  in  1  pixel clock; also the FIFO rd_clk
- rst_n  in  1  **one clock; reset is asynchronous and active-low**
- enable  in  1  run request, level-sensitive
- fifo_rd_data  in  24  FIFO read data, {R[23:16],G[15:8],B[7:0]}
- fifo_rd_empty  in  1  FIFO empty
- fifo_almost_full  in  1  FIFO prefill reached
- fifo_rd_en  out  1  FIFO read strobe, combinational from registered state
- vid_hs  out  1  hsync
- vid_vs  out  1  vsync
- vid_de  out  1  data enable
- vid_data  out  24  pixel data
- frame_start  out  1  one-cycle pulse when the counters enter (h=0, v=0) in RUN
- underflow  out  1  one-cycle pulse, aligned with vid_de, for a pixel whose read was skipped
- underflow_sticky  out  1  set on any underflow; cleared by reset or by a transition to IDLE

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise. Counters h_cnt and v_cnt are 12 bits.
- Line order: active h∈[0,H_ACTIVE), then FP, then SYNC, then BP. Frame order is the same in v.
- Internal de_i = RUN && h<H_ACTIVE && v<V_ACTIVE.
- hs_i is active during h∈[H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs_i follows the same rule in v.
- State machine:
  - IDLE: counters 0, no reads. Go to WAIT_FILL when enable=1.
  - WAIT_FILL: go to RUN when fifo_almost_full=1. Go back to IDLE if enable=0 first.
  - RUN: h increments and wraps at H_TOTAL-1. v increments on each h wrap and wraps at V_TOTAL-1. If enable=0 when (h,v)=(H_TOTAL-1,V_TOTAL-1), go to IDLE.
  - enable dropping mid-frame has no effect until the frame's last cycle.
- fifo_rd_en = de_i && !fifo_rd_empty. A pixel with de_i && fifo_rd_empty is an underflow: no read is issued, and that pixel's vid_data is 0x000000.
- de_i, hs_i, vs_i and a valid bit (rd_en) pass through an RD_LAT-deep delay line.
- Output register stage captures the delayed signals plus fifo_rd_data when valid, else 0.
- In IDLE and WAIT_FILL: sync outputs are at their inactive level (~POL) and de=0.
- Reset values: vid_hs=~HS_POL, vid_vs=~VS_POL, vid_de=0, vid_data=0, fifo_rd_en=0, frame_start=0, underflow=0, underflow_sticky=0, state=IDLE, delay line cleared.

## Timing
- Counter position at cycle t appears on vid_* at cycle t+RD_LAT+1. fifo_rd_en is issued in cycle t.
- frame_start is undelayed, in cycle t where (h,v)=(0,0). Upstream zoom uses it as the frame trigger.
- WAIT_FILL→RUN takes 1 cycle after almost_full is sampled. The first RUN cycle has (0,0).
- RUN→IDLE: the pipeline drains over RD_LAT+1 cycles, with outputs going inactive as the drain completes.
- Empty deasserting mid-line resumes reads on the next cycle. There is no retry: skipped pixels are lost.
- Async reset mid-frame: all outputs return to reset values immediately, state goes to IDLE, and the next run waits for prefill again.

## Structure
- Shared package/include zoom_hdmi_pkg:
  - state encoding localparams (IDLE=2'd0, WAIT_FILL=2'd1, RUN=2'd2)
  - default 720p timing constants
  - RGB field offsets
- One sub-module, zoom_hdmi_delay_line: parameterized width × depth register shift line with async active-low reset. Instantiated once with width 4 (de, hs, vs, valid) and depth RD_LAT.

## Test plan
All cases use H=8/2/2/2 and V=4/1/1/1 (H_TOTAL=14, V_TOTAL=7, 98 cycles/frame), with a FIFO model of latency 2 preloaded with 0xFFFFFF, 0xFFFFFE, ….
- Start-up: enable=1 with almost_full low for 20 cycles → fifo_rd_en=0 and vid_de=0. Raise almost_full → frame_start one cycle later; first vid_de=1 three cycles after that, with vid_data=0xFFFFFF.
- Full frame: count outputs → exactly 32 vid_de cycles with descending data, 7 vid_hs pulses of 2 cycles each, and one vid_vs of 14 cycles.
- Underflow: force empty for pixels 3–4 of line 0 → vid_data=0 with underflow=1 on those cycles, underflow_sticky=1, and pixel 5 = the next FIFO word.
- Stop: drop enable at frame midpoint → frame completes with all 32 de; IDLE next; no frame_start; syncs inactive.
- Polarity: HS_POL=0, VS_POL=0 → vid_hs/vid_vs idle high and pulse low with the same widths.
- Reset: assert rst_n=0 at line 2 → outputs at reset values in the same cycle; after release with enable=1, reads only start once almost_full is seen again.
